// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// opcodes, R-type functs, ALU codes, FSM states and decoded control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;

  // Path class selects which state sequence an instruction walks through.
  typedef enum logic [2:0] {P_ALU, P_LW, P_SW, P_BEQ, P_J, P_ILL} path_e;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic [2:0] aluctl;
    path_e      path;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Instruction handshake plus datapath control/status bundle of the sequencer.
interface mips_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        isZero;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        RegWrite;
  logic        RegDst;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToReg;
  logic        ALUSrc;
  logic [2:0]  ALUcontrol;
  logic [31:0] pc;
  logic        done;
  logic        illegal;

  modport master (
    output instr, instr_valid, isZero,
    input  instr_ready, rs, rt, rd, imm, RegWrite, RegDst, MemRead, MemWrite,
           MemToReg, ALUSrc, ALUcontrol, pc, done, illegal
  );

  modport slave (
    input  instr, instr_valid, isZero,
    output instr_ready, rs, rt, rd, imm, RegWrite, RegDst, MemRead, MemWrite,
           MemToReg, ALUSrc, ALUcontrol, pc, done, illegal
  );
endinterface

// File: rtl/mips_ctrl_decoder.sv
// Combinational opcode/funct decode into static datapath controls and path class.
module mips_ctrl_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  // Anything not matched falls through as an illegal path with all controls low.
  always_comb begin
    ctrl      = '0;
    ctrl.path = P_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin ctrl.regdst = 1'b1; ctrl.aluctl = ALU_ADD; ctrl.path = P_ALU; end
          FN_SUB:  begin ctrl.regdst = 1'b1; ctrl.aluctl = ALU_SUB; ctrl.path = P_ALU; end
          FN_AND:  begin ctrl.regdst = 1'b1; ctrl.aluctl = ALU_AND; ctrl.path = P_ALU; end
          FN_OR:   begin ctrl.regdst = 1'b1; ctrl.aluctl = ALU_OR;  ctrl.path = P_ALU; end
          FN_SLT:  begin ctrl.regdst = 1'b1; ctrl.aluctl = ALU_SLT; ctrl.path = P_ALU; end
          default: ctrl.path = P_ILL;
        endcase
      end
      OP_ADDI: begin ctrl.alusrc = 1'b1; ctrl.aluctl = ALU_ADD; ctrl.path = P_ALU; end
      OP_LW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.aluctl   = ALU_ADD;
        ctrl.path     = P_LW;
      end
      OP_SW:   begin ctrl.alusrc = 1'b1; ctrl.aluctl = ALU_ADD; ctrl.path = P_SW; end
      OP_BEQ:  begin ctrl.aluctl = ALU_SUB; ctrl.path = P_BEQ; end
      OP_J:    ctrl.path = P_J;
      default: ctrl.path = P_ILL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: latches one instruction, sequences the datapath
// strobes through DECODE/EXEC/MEM/WB, owns the PC and pulses done on retire.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
)(
  input logic                    clk,
  input logic                    rst,
  mips_multicycle_ctrl_if.slave  bus
);

  state_e      state;
  logic [31:0] ir;
  logic [31:0] pc;
  ctrl_t       ctrl_q;
  ctrl_t       dec;
  logic        retire;
  logic [31:0] npc;
  logic [31:0] p4;
  logic [31:0] br_target;
  logic [31:0] j_target;

  // Only the incoming word is decoded; the result is registered at accept.
  mips_ctrl_decoder u_dec (
    .opcode (bus.instr[31:26]),
    .funct  (bus.instr[5:0]),
    .ctrl   (dec)
  );

  assign p4        = pc + PC_STEP;
  assign br_target = p4 + {{14{ir[15]}}, ir[15:0], 2'b00};
  assign j_target  = {p4[31:28], ir[25:0], 2'b00};

  // Retire is the last busy cycle of each path; npc is what pc takes at that edge.
  always_comb begin
    retire = 1'b0;
    npc    = p4;
    case (state)
      S_DECODE: begin
        if (ctrl_q.path == P_J) begin
          retire = 1'b1;
          npc    = j_target;
        end else if (ctrl_q.path == P_ILL) begin
          retire = 1'b1;
        end
      end
      S_EXEC: begin
        if (ctrl_q.path == P_BEQ) begin
          retire = 1'b1;
          npc    = bus.isZero ? br_target : p4;
        end
      end
      S_MEM:   retire = (ctrl_q.path == P_SW);
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // Strobes are set on the edge entering the state that owns them, so they are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ir           <= '0;
      pc           <= PC_RESET;
      ctrl_q       <= '0;
      bus.RegWrite <= 1'b0;
      bus.MemRead  <= 1'b0;
      bus.MemWrite <= 1'b0;
      bus.done     <= 1'b0;
      bus.illegal  <= 1'b0;
    end else begin
      bus.done     <= 1'b0;
      bus.illegal  <= 1'b0;
      bus.RegWrite <= 1'b0;
      bus.MemRead  <= 1'b0;
      bus.MemWrite <= 1'b0;
      if (retire) begin
        state       <= S_IDLE;
        pc          <= npc;
        bus.done    <= 1'b1;
        bus.illegal <= (ctrl_q.path == P_ILL);
        ctrl_q      <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.instr_valid) begin
              ir     <= bus.instr;
              ctrl_q <= dec;
              state  <= S_DECODE;
            end
          end
          S_DECODE: state <= S_EXEC;
          S_EXEC: begin
            if (ctrl_q.path == P_LW || ctrl_q.path == P_SW) begin
              state        <= S_MEM;
              bus.MemRead  <= (ctrl_q.path == P_LW);
              bus.MemWrite <= (ctrl_q.path == P_SW);
            end else begin
              state        <= S_WB;
              bus.RegWrite <= 1'b1;
            end
          end
          S_MEM: begin
            state        <= S_WB;
            bus.MemRead  <= 1'b1;
            bus.RegWrite <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.pc          = pc;
  assign bus.rs          = ir[25:21];
  assign bus.rt          = ir[20:16];
  assign bus.rd          = ir[15:11];
  assign bus.imm         = ir[15:0];
  assign bus.RegDst      = ctrl_q.regdst;
  assign bus.ALUSrc      = ctrl_q.alusrc;
  assign bus.MemToReg    = ctrl_q.memtoreg;
  assign bus.ALUcontrol  = ctrl_q.aluctl;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: directed instructions push expected
// retire records; a negedge monitor tracks strobes and compares on each done pulse.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();
  mips_multicycle_ctrl_if bus2 ();

  mips_multicycle_ctrl #(.PC_RESET(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mips_multicycle_ctrl #(.PC_RESET(32'h4000_0000)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ill;
    int          lat;
    int          rwc;
    int          rwo;
    int          mrc;
    int          mwc;
    logic [2:0]  alu;
    logic        rdst;
    logic        asrc;
    logic        mtr;
    logic [4:0]  rt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor state: accept cycle, strobe counters and statics captured in DECODE.
  int         cyc = 0;
  bit         busy = 0;
  int         accCyc = 0;
  int         rwc, mrc, mwc, rwo;
  logic [2:0] capAlu;
  logic       capRdst, capAsrc, capMtr;
  logic [4:0] capRt;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy = 0;
      end else begin
        if (busy) begin
          if (cyc == accCyc + 1) begin
            capAlu  = bus.ALUcontrol;
            capRdst = bus.RegDst;
            capAsrc = bus.ALUSrc;
            capMtr  = bus.MemToReg;
            capRt   = bus.rt;
          end
          if (bus.RegWrite) begin
            rwc++;
            if (rwo == 0) rwo = cyc - accCyc;
          end
          if (bus.MemRead)  mrc++;
          if (bus.MemWrite) mwc++;
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            checkOutput("spurious_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("pc",        bus.pc, e.pc);
            checkOutput("illegal",   {31'd0, bus.illegal}, {31'd0, e.ill});
            checkOutput("latency",   32'(cyc - accCyc), 32'(e.lat));
            checkOutput("regwr_cnt", 32'(rwc), 32'(e.rwc));
            checkOutput("regwr_off", 32'(rwo), 32'(e.rwo));
            checkOutput("memrd_cnt", 32'(mrc), 32'(e.mrc));
            checkOutput("memwr_cnt", 32'(mwc), 32'(e.mwc));
            checkOutput("aluctl",    {29'd0, capAlu}, {29'd0, e.alu});
            checkOutput("regdst",    {31'd0, capRdst}, {31'd0, e.rdst});
            checkOutput("alusrc",    {31'd0, capAsrc}, {31'd0, e.asrc});
            checkOutput("memtoreg",  {31'd0, capMtr}, {31'd0, e.mtr});
            checkOutput("rt_field",  {27'd0, capRt}, {27'd0, e.rt});
            checkOutput("idle_statics",
                        {28'd0, bus.ALUcontrol, bus.ALUSrc | bus.RegDst | bus.MemToReg}, 32'd0);
          end
          busy = 0;
        end
        if (bus.instr_valid && bus.instr_ready) begin
          busy   = 1;
          accCyc = cyc;
          rwc = 0; mrc = 0; mwc = 0; rwo = 0;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic isz,
                               input logic [31:0] epc, input logic eill, input int elat,
                               input int erwc, input int erwo, input int emrc, input int emwc,
                               input logic [2:0] ealu, input logic erdst, input logic easrc,
                               input logic emtr);
    exp_t e;
    int   waitCnt;
    e.pc = epc; e.ill = eill; e.lat = elat; e.rwc = erwc; e.rwo = erwo;
    e.mrc = emrc; e.mwc = emwc; e.alu = ealu; e.rdst = erdst; e.asrc = easrc;
    e.mtr = emtr; e.rt = instr[20:16];
    sb.push_back(e);
    bus.instr       = instr;
    bus.instr_valid = 1'b1;
    waitCnt = 0;
    do begin
      @(negedge clk);
      waitCnt++;
    end while (!bus.instr_ready && waitCnt < 20);
    if (!bus.instr_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.isZero      = isz;
  endtask

  initial begin
    int n;
    bit seen;
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    bit  seen;
    bus.instr = '0;  bus.instr_valid = 1'b0;  bus.isZero = 1'b0;
    bus2.instr = '0; bus2.instr_valid = 1'b0; bus2.isZero = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_pc",       bus.pc, 32'h0);
    checkOutput("rst_ready",    {31'd0, bus.instr_ready}, 32'd1);
    checkOutput("rst_strobes",  {28'd0, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.done}, 32'd0);
    checkOutput("rst_illegal",  {31'd0, bus.illegal}, 32'd0);
    checkOutput("rst_pc2",      bus2.pc, 32'h4000_0000);

    // j 0x0000100 from pc 0x4000_0000 on the second instance.
    @(posedge clk); #1;
    bus2.instr = 32'h0800_0100; bus2.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus2.instr_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus2.done && n < 10);
    checkOutput("j_high_latency", 32'(n), 32'd2);
    checkOutput("j_high_pc",      bus2.pc, 32'h4000_0400);
    checkOutput("j_high_illegal", {31'd0, bus2.illegal}, 32'd0);

    @(posedge clk); #1;
    //            instr         isZ  pc          ill lat rwc rwo mrc mwc alu     rdst asrc mtr
    applyStimulus(32'h00221820, 0, 32'h0000_0004, 0, 4, 1, 3, 0, 0, 3'b010, 1, 0, 0);
    applyStimulus(32'h8C050008, 0, 32'h0000_0008, 0, 5, 1, 4, 2, 0, 3'b010, 0, 1, 1);
    applyStimulus(32'hAC050004, 0, 32'h0000_000C, 0, 4, 0, 0, 0, 1, 3'b010, 0, 1, 0);
    applyStimulus(32'hFC000000, 0, 32'h0000_0010, 1, 2, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    applyStimulus(32'h10000003, 1, 32'h0000_0020, 0, 3, 0, 0, 0, 0, 3'b110, 0, 0, 0);
    applyStimulus(32'h08000004, 0, 32'h0000_0010, 0, 2, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    applyStimulus(32'h10000003, 0, 32'h0000_0014, 0, 3, 0, 0, 0, 0, 3'b110, 0, 0, 0);
    applyStimulus(32'h00222022, 0, 32'h0000_0018, 0, 4, 1, 3, 0, 0, 3'b110, 1, 0, 0);
    applyStimulus(32'h00222025, 0, 32'h0000_001C, 0, 4, 1, 3, 0, 0, 3'b001, 1, 0, 0);
    applyStimulus(32'h0022202A, 0, 32'h0000_0020, 0, 4, 1, 3, 0, 0, 3'b111, 1, 0, 0);
    applyStimulus(32'h00222024, 0, 32'h0000_0024, 0, 4, 1, 3, 0, 0, 3'b000, 1, 0, 0);
    applyStimulus(32'h20060005, 0, 32'h0000_0028, 0, 4, 1, 3, 0, 0, 3'b010, 0, 1, 0);
    applyStimulus(32'h00000001, 0, 32'h0000_002C, 1, 2, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    applyStimulus(32'h1000FFFE, 1, 32'h0000_0028, 0, 3, 0, 0, 0, 0, 3'b110, 0, 0, 0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);

    // sw aborted by reset while in MEM: MemWrite must fall without a clock edge.
    @(posedge clk); #1;
    bus.instr = 32'hAC050004; bus.instr_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    seen = 0;
    n = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (bus.MemWrite) seen = 1;
    end
    checkOutput("sw_memwrite_seen", {31'd0, seen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_memwrite", {31'd0, bus.MemWrite}, 32'd0);
    checkOutput("abort_pc",       bus.pc, 32'h0);
    checkOutput("abort_ready",    {31'd0, bus.instr_ready}, 32'd1);
    checkOutput("abort_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    checkOutput("abort_done",     {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    @(posedge clk); #1;
    applyStimulus(32'h00221820, 0, 32'h0000_0004, 0, 4, 1, 3, 0, 0, 3'b010, 1, 0, 0);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("final_drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
